// File: rtl/timer_pkg.sv
// Shared constants and types for the anti-theft countdown timer bank.
// Channel indices name the role each channel plays in the alarm controller.
package timer_pkg;

   localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

   localparam int CH_ARM       = 0;
   localparam int CH_DRIVER    = 1;
   localparam int CH_PASSENGER = 2;
   localparam int CH_ALARM     = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chanState_e;

endpackage

// File: rtl/countdown_channel.sv
// One seconds countdown channel: load, decrement on each 1 Hz tick, flag expiry.
// Cancel outranks start, and start outranks a coincident tick.
module countdown_channel
   import timer_pkg::*;
#(
   parameter int VALUE_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               cancel,
   input  logic [VALUE_W-1:0] value,
   input  logic               tick,
   output logic               busy,
   output logic               expired,
   output logic               expired_pulse,
   output logic [VALUE_W-1:0] remaining
);

   chanState_e         state_q;
   logic [VALUE_W-1:0] remaining_q;
   logic               expired_q;
   logic               pulse_q;

   // A zero load expires on the spot; a count of one expires on the next tick.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         expired_q   <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (cancel) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            expired_q   <= 1'b0;
         end else if (start) begin
            if (value != '0) begin
               state_q     <= RUN;
               remaining_q <= value;
               expired_q   <= 1'b0;
            end else begin
               state_q     <= IDLE;
               remaining_q <= '0;
               expired_q   <= 1'b1;
               pulse_q     <= 1'b1;
            end
         end else if (state_q == RUN && tick) begin
            if (remaining_q > VALUE_W'(1)) begin
               remaining_q <= remaining_q - VALUE_W'(1);
            end else begin
               state_q     <= IDLE;
               remaining_q <= '0;
               expired_q   <= 1'b1;
               pulse_q     <= 1'b1;
            end
         end
      end
   end

   assign busy          = (state_q == RUN);
   assign expired       = expired_q;
   assign expired_pulse = pulse_q;
   assign remaining     = remaining_q;

endmodule

// File: rtl/timer_bank.sv
// Free-running 1 Hz / 2 Hz prescaler feeding a bank of independent countdown channels.
// The strobes are registered, so each fires the cycle after its counter wraps.
module timer_bank
   import timer_pkg::*;
#(
   parameter int unsigned CLK_HZ   = CLK_HZ_DEFAULT,
   parameter int          CHANNELS = 4,
   parameter int          VALUE_W  = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           start,
   input  logic [CHANNELS-1:0]           cancel,
   input  logic [CHANNELS*VALUE_W-1:0]   value,
   output logic                          one_hz_enable,
   output logic                          two_hz_enable,
   output logic [CHANNELS-1:0]           busy,
   output logic [CHANNELS-1:0]           expired,
   output logic [CHANNELS-1:0]           expired_pulse,
   output logic [CHANNELS*VALUE_W-1:0]   remaining
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] ONE_LAST = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] TWO_LAST = CNT_W'(CLK_HZ / 2 - 1);

   logic [CNT_W-1:0] oneCount_q, oneCount_d;
   logic [CNT_W-1:0] twoCount_q, twoCount_d;
   logic             oneWrap, twoWrap;
   logic             oneHz_q, twoHz_q;

   // Both counters start together, so every 1 Hz wrap lands on a 2 Hz wrap.
   always_comb begin
      oneWrap    = (oneCount_q == ONE_LAST);
      twoWrap    = (twoCount_q == TWO_LAST);
      oneCount_d = oneWrap ? '0 : oneCount_q + CNT_W'(1);
      twoCount_d = twoWrap ? '0 : twoCount_q + CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         oneCount_q <= '0;
         twoCount_q <= '0;
         oneHz_q    <= 1'b0;
         twoHz_q    <= 1'b0;
      end else begin
         oneCount_q <= oneCount_d;
         twoCount_q <= twoCount_d;
         oneHz_q    <= oneWrap;
         twoHz_q    <= twoWrap;
      end
   end

   assign one_hz_enable = oneHz_q;
   assign two_hz_enable = twoHz_q;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      countdown_channel #(
         .VALUE_W(VALUE_W)
      ) u_chan (
         .clock        (clock),
         .reset        (reset),
         .start        (start[c]),
         .cancel       (cancel[c]),
         .value        (value[c*VALUE_W +: VALUE_W]),
         .tick         (oneHz_q),
         .busy         (busy[c]),
         .expired      (expired[c]),
         .expired_pulse(expired_pulse[c]),
         .remaining    (remaining[c*VALUE_W +: VALUE_W])
      );
   end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel countdown timer for the automotive anti-theft controller. A single free-running prescaler produces 1 Hz and 2 Hz enable strobes. `CHANNELS` independent countdown channels each load a seconds value, decrement once per 1 Hz strobe, and flag expiry. The FSM uses the channels for the arming delay, driver-door delay, passenger-door delay and alarm-on duration. It uses the 2 Hz strobe for the status-LED blink.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, clock frequency. Must be even and ≥ 2.
- `CHANNELS`, 4, number of countdown channels.
- `VALUE_W`, 4, width of each channel's seconds value.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  CHANNELS  per-channel load/restart request, sampled every cycle.
- `cancel`  in  CHANNELS  per-channel abort request.
- `value`  in  CHANNELS*VALUE_W  load values, flattened. Channel c occupies bits [c*VALUE_W +: VALUE_W].
- `one_hz_enable`  out  1  single-cycle strobe every `CLK_HZ` cycles.
- `two_hz_enable`  out  1  single-cycle strobe every `CLK_HZ/2` cycles.
- `busy`  out  CHANNELS  channel is counting.
- `expired`  out  CHANNELS  sticky expiry level.
- `expired_pulse`  out  CHANNELS  one-cycle expiry event.
- `remaining`  out  CHANNELS*VALUE_W  current count per channel, same packing as `value`.

## Operation
Prescaler:
- Counters run freely from reset and are never cleared by `start` or `cancel`.
- `one_hz_enable` is 1 in the cycle after the 1 Hz counter reaches `CLK_HZ-1`.
- `two_hz_enable` is 1 in the cycle after the 2 Hz counter reaches `CLK_HZ/2-1`.
- Every 1 Hz strobe coincides with a 2 Hz strobe.

Each channel is a two-state FSM, IDLE and RUN. `expired` is a flag, independent of state.

Priority per channel, evaluated per cycle:
1. `cancel`: go to IDLE; `remaining` = 0; `expired` = 0. Cancel wins over a coincident `start`.
2. `start` with `value` = V:
   - V > 0: go to RUN; `remaining` = V; `expired` = 0.
   - V = 0: stay in or return to IDLE; `remaining` = 0; `expired` = 1; `expired_pulse` = 1.
   - `start` while in RUN reloads (restart).
   - Load wins over a coincident 1 Hz strobe; no decrement in that cycle.
3. RUN and `one_hz_enable`:
   - `remaining` > 1: decrement.
   - `remaining` = 1: `remaining` = 0; go to IDLE; `expired` = 1; `expired_pulse` = 1.
4. Otherwise hold.

Additional rules:
- `busy` = (state == RUN).
- `expired` holds until the next `start` or `cancel` on that channel.
- Arithmetic is unsigned, `VALUE_W` bits. `remaining` never decrements below 0 and never wraps.
- A value of all ones is legal: 2^VALUE_W − 1 seconds.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

## Timing
- Reset values: prescaler counters 0; `one_hz_enable` = 0; `two_hz_enable` = 0; `busy` = 0; `expired` = 0; `expired_pulse` = 0; `remaining` = 0.
- All outputs are registered.
- `start` or `cancel` in cycle t: `busy`, `remaining` and `expired` update at t+1.
- A start with V = 0 in cycle t gives `expired_pulse` high in t+1 only.
- Expiry is produced by the strobe cycle: `one_hz_enable` high in cycle t with `remaining` = 1 gives `expired_pulse` high in t+1 only.
- Duration quantisation: the first decrement occurs on the first strobe after the load cycle. Time from start to expiry is therefore between (V−1)·`CLK_HZ`+1 and V·`CLK_HZ` cycles. The FSM accepts this.
- First `one_hz_enable` after reset release: cycle `CLK_HZ`. First `two_hz_enable`: cycle `CLK_HZ/2`.
- Reset asserted mid-count aborts everything immediately, asynchronously.

## Structure
- Package `timer_pkg` holds:
  - default `CLK_HZ`;
  - the channel index constants `CH_ARM`, `CH_DRIVER`, `CH_PASSENGER`, `CH_ALARM`;
  - the channel-state enum {IDLE, RUN}.
- Sub-module `countdown_channel` implements one channel. Its inputs are `start`, `cancel`, `value` and the tick; its outputs are `busy`, `expired`, `expired_pulse` and `remaining`.
- `timer_bank` instantiates `countdown_channel` in a generate loop. The prescaler is inline.

## Test plan
All scenarios run with `CLK_HZ`=8, `CHANNELS`=4, `VALUE_W`=4.
- Reset release, then free run:
  - `one_hz_enable` high at cycles 8, 16, 24;
  - `two_hz_enable` high at cycles 4, 8, 12, 16;
  - all outputs 0 during reset.
- Ch0 start with V=3:
  - `remaining` steps 3→2→1→0 on successive 1 Hz strobes;
  - `expired_pulse[0]` high exactly one cycle after the third strobe;
  - `expired[0]` stays high and `busy[0]` drops at the same time.
- Ch1 start with V=0:
  - `expired_pulse[1]` and `expired[1]` high the next cycle;
  - `busy[1]` never rises.
- Ch2 start with V=5, then `start` with V=2 after two strobes: reload to 2, then expiry after two more strobes. Then `start` together with `cancel`: channel goes to IDLE, `remaining` = 0, `expired` = 0.
- Load coincident with a 1 Hz strobe: no decrement that cycle. Ch3 start with V=15 (max): 15 decrements, then expiry.
- Reset asserted mid-count on all channels at once: all outputs 0 immediately; the prescaler restarts from 0 after release.
